traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Moore traffic-light controller for a two-road intersection (roads A and B). It sits directly downstream of the divide-by-3 tick generator: that block's single-cycle `y` pulse drives this block's `tick` input, and all timing here is measured in ticks, not clock cycles. Sensor inputs request a change of right-of-way; the block drives encoded light colours for both roads.

## Interface
- `MIN_GREEN`, default 2: minimum ticks a road stays green; legal range ≥1.
- `YEL_TICKS`, default 1: ticks a road stays yellow; legal range ≥1.
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high.
- `tick`  in  1: single-cycle enable from the tick generator. All state and counter updates occur only on `clk` edges where `tick`=1.
- `ta`  in  1: traffic present on road A; holds A green.
- `tb`  in  1: traffic present on road B; holds B green.
- `la`  out  2: road A light, type `light_t`.
- `lb`  out  2: road B light, type `light_t`.
- `state_o`  out  2: current state, for debug and bench observation.

## Operation
- Light encoding: GREEN=2'b00, YELLOW=2'b01, RED=2'b10. Code 2'b11 is never driven.
- States:
  - S0: `la`=GREEN, `lb`=RED.
  - S1: `la`=YELLOW, `lb`=RED.
  - S2: `la`=RED, `lb`=GREEN.
  - S3: `la`=RED, `lb`=YELLOW.
- Dwell counter `cnt`:
  - Width is $clog2(max(MIN_GREEN,YEL_TICKS))+1.
  - Cleared to 0 on every state change.
- Transitions are evaluated only when `tick`=1:
  - S0: if `cnt`==MIN_GREEN-1 and `ta`=0, go to S1. Otherwise `cnt` increments, saturating at MIN_GREEN-1.
  - S1: if `cnt`==YEL_TICKS-1, go to S2. Otherwise `cnt`++.
  - S2: if `cnt`==MIN_GREEN-1 and `tb`=0, go to S3. Otherwise `cnt` increments, saturating at MIN_GREEN-1.
  - S3: if `cnt`==YEL_TICKS-1, go to S0. Otherwise `cnt`++.
  - Illegal or unreachable encoding: go to S0, `cnt`=0.
- Sensors are sampled only on tick cycles. Sensor changes between ticks have no effect.
- Yellow phases ignore the sensors entirely.

## Timing
- Reset values, asserted asynchronously and immediately: state=S0, `cnt`=0, `la`=GREEN, `lb`=RED, `state_o`=2'b00.
- Outputs are pure Moore decode of the state register. They change in the same cycle the state register updates, one clk edge after the qualifying tick is sampled.
- With `tick`=0, state and `cnt` hold indefinitely.
- `reset` together with `tick`: reset wins.
- Reset in any state, including mid-yellow: immediate return to S0 with `cnt`=0. There is no partial-phase resume.
- Shortest full cycle, with `ta`=`tb`=0: 2·(MIN_GREEN+YEL_TICKS) ticks. With the defaults this is 6 ticks, i.e. 18 clk cycles when fed by the divide-by-3 block.
- Back-to-back ticks (`tick` tied high) are legal: the block then runs in clock cycles.

## Structure
- Package `traffic_pkg` holds:
  - `typedef enum logic [1:0] {S0,S1,S2,S3} statetype`
  - `typedef enum logic [1:0] {GREEN=2'b00,YELLOW=2'b01,RED=2'b10} light_t`
  - the constant helper used to size `cnt`.
- Internal organisation, all inside the one module:
  - one async-reset `always_ff` for state and `cnt`;
  - one `always_comb` for next-state and next-count;
  - one `always_comb` for output decode.
- No sub-module inside the block.
- The bench top instantiates `divby3` to generate `tick`.

## Test plan
1. Assert `reset` mid-cycle with no clock edge -> `la`=GREEN, `lb`=RED, `state_o`=0 immediately.
2. Defaults, `ta`=1, `tb`=0, 10 ticks -> stays S0 and `cnt` saturates at 1. Then drop `ta` -> S1 on the next tick, S2 on the tick after.
3. Defaults, `ta`=`tb`=0 from reset, tick from `divby3` -> `state_o` sequence 0,0,1,2,2,3,0 on successive ticks. Each state change lands exactly on a clk edge where `tick`=1.
4. `tick` held 0 for 20 cycles while `ta`/`tb` toggle every cycle -> `state_o`, `la` and `lb` constant.
5. Assert reset while in S1, with `YEL_TICKS`=3 and `cnt`=1 -> S0, `la`=GREEN, `cnt`=0. Then a further MIN_GREEN ticks with `ta`=0 are needed before S1 is re-entered.
6. `MIN_GREEN`=1, `YEL_TICKS`=1, `tick` tied 1, `ta`=`tb`=0 -> state cycles 0,1,2,3,0 every clk. `la`/`lb` never both non-RED, and never 2'b11.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and sizing helper for the two-road traffic-light controller.
package traffic_pkg;

    typedef enum logic [1:0] {S0, S1, S2, S3} statetype;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    // Dwell counter must hold the larger of the green and yellow terminal counts.
    function automatic int cnt_width(input int min_green, input int yel_ticks);
        int m;
        m = (min_green > yel_ticks) ? min_green : yel_ticks;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/divby3.sv
// Divide-by-3 tick generator: y pulses high for one clk cycle out of every three.
module divby3 (
    input  logic clk,
    input  logic reset,
    output logic y
);

    typedef enum logic [1:0] {D0, D1, D2} div_state_t;

    div_state_t state, next_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= D0;
        else       state <= next_state;
    end

    always_comb begin
        next_state = D0;
        case (state)
            D0:      next_state = D1;
            D1:      next_state = D2;
            default: next_state = D0;
        endcase
    end

    assign y = (state == D0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Moore traffic-light controller for roads A and B; all timing counted in tick pulses.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 2,
    parameter int YEL_TICKS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ta,
    input  logic       tb,
    output logic [1:0] la,
    output logic [1:0] lb,
    output logic [1:0] state_o
);

    localparam int CW = cnt_width(MIN_GREEN, YEL_TICKS);
    localparam logic [CW-1:0] GREEN_LAST = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] YEL_LAST   = CW'(YEL_TICKS - 1);

    statetype        state, next_state;
    logic [CW-1:0]   cnt, next_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        if (tick) begin
            case (state)
                S0: begin
                    if (cnt == GREEN_LAST && !ta) begin
                        next_state = S1;
                        next_cnt   = '0;
                    end else if (cnt != GREEN_LAST) begin
                        next_cnt = cnt + 1'b1;
                    end
                end
                S1: begin
                    if (cnt == YEL_LAST) begin
                        next_state = S2;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt + 1'b1;
                    end
                end
                S2: begin
                    if (cnt == GREEN_LAST && !tb) begin
                        next_state = S3;
                        next_cnt   = '0;
                    end else if (cnt != GREEN_LAST) begin
                        next_cnt = cnt + 1'b1;
                    end
                end
                S3: begin
                    if (cnt == YEL_LAST) begin
                        next_state = S0;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt + 1'b1;
                    end
                end
                default: begin
                    next_state = S0;
                    next_cnt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        la = RED;
        lb = RED;
        case (state)
            S0:      la = GREEN;
            S1:      la = YELLOW;
            S2:      lb = GREEN;
            S3:      lb = YELLOW;
            default: begin
                la = RED;
                lb = RED;
            end
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: vector table plus multi-cycle corner sequences.
module tb_traffic_light_ctrl;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ta = 1'b0;
    logic       tb = 1'b0;
    logic       man_tick = 1'b0;
    logic       use_div = 1'b0;
    logic       tick_y = 1'b0;
    logic       div_y;
    logic       tick_a;

    logic [1:0] la_a, lb_a, st_a;
    logic [1:0] la_y, lb_y, st_y;
    logic [1:0] la_f, lb_f, st_f;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    divby3 u_div (.clk(clk), .reset(reset), .y(div_y));

    assign tick_a = use_div ? div_y : man_tick;

    traffic_light_ctrl u_a (
        .clk(clk), .reset(reset), .tick(tick_a), .ta(ta), .tb(tb),
        .la(la_a), .lb(lb_a), .state_o(st_a)
    );

    traffic_light_ctrl #(.MIN_GREEN(2), .YEL_TICKS(3)) u_y (
        .clk(clk), .reset(reset), .tick(tick_y), .ta(ta), .tb(tb),
        .la(la_y), .lb(lb_y), .state_o(st_y)
    );

    traffic_light_ctrl #(.MIN_GREEN(1), .YEL_TICKS(1)) u_f (
        .clk(clk), .reset(reset), .tick(1'b1), .ta(ta), .tb(tb),
        .la(la_f), .lb(lb_f), .state_o(st_f)
    );

    typedef struct {
        logic       tick;
        logic       ta;
        logic       tb;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_la(input int st);
        case (st)
            0:       return int'(GREEN);
            1:       return int'(YELLOW);
            default: return int'(RED);
        endcase
    endfunction

    function automatic int exp_lb(input int st);
        case (st)
            2:       return int'(GREEN);
            3:       return int'(YELLOW);
            default: return int'(RED);
        endcase
    endfunction

    // Advance one clk edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, check the asynchronous effect, then release after an edge.
    task automatic apply_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check({tag, "_rst_state"}, st_a, 0);
        check({tag, "_rst_la"}, la_a, int'(GREEN));
        check({tag, "_rst_lb"}, lb_a, int'(RED));
        step();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'd1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'd2};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'd2};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 2'd2};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'd3};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 2'd3};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 2'd0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 2'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 2'd1};

        // Reset is high from time zero, before any clock edge.
        #1;
        check("init_state", st_a, 0);
        check("init_la", la_a, int'(GREEN));
        check("init_lb", lb_a, int'(RED));
        step();
        reset = 1'b0;

        // Vector table on the default-parameter instance with manual ticks.
        for (int i = 0; i < 14; i++) begin
            man_tick = vecs[i].tick;
            ta       = vecs[i].ta;
            tb       = vecs[i].tb;
            step();
            check($sformatf("vec%0d_state", i), st_a, int'(vecs[i].st));
            check($sformatf("vec%0d_la", i), la_a, exp_la(int'(vecs[i].st)));
            check($sformatf("vec%0d_lb", i), lb_a, exp_lb(int'(vecs[i].st)));
        end
        man_tick = 1'b0;

        // Traffic on A holds green; the counter saturates, so release moves on at the next tick.
        apply_reset("hold");
        ta = 1'b1;
        man_tick = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("hold%0d_state", i), st_a, 0);
        end
        check("hold_cnt_sat", int'(u_a.cnt), 1);
        ta = 1'b0;
        step();
        check("release_s1", st_a, 1);
        step();
        check("release_s2", st_a, 2);
        man_tick = 1'b0;

        // Tick held low: sensor chatter must not move state or lights.
        apply_reset("idle");
        man_tick = 1'b1;
        for (int i = 0; i < 3; i++) step();
        man_tick = 1'b0;
        check("idle_pre_state", st_a, 2);
        for (int i = 0; i < 20; i++) begin
            ta = ~ta;
            tb = ~tb;
            step();
            check($sformatf("idle%0d_state", i), st_a, 2);
            check($sformatf("idle%0d_la", i), la_a, int'(RED));
            check($sformatf("idle%0d_lb", i), lb_a, int'(GREEN));
        end
        ta = 1'b0;
        tb = 1'b0;

        // Mid-cycle asynchronous reset out of S2.
        apply_reset("async");

        // Free-running ticks from divby3: state sampled at each tick.
        begin
            int seq[7];
            int k;
            logic prev_tick;
            logic [1:0] prev_state;
            seq = '{0, 0, 1, 2, 2, 3, 0};
            k = 0;
            apply_reset("div");
            use_div = 1'b1;
            for (int c = 0; c < 40 && k < 7; c++) begin
                if (div_y) begin
                    check($sformatf("div_tick%0d_state", k), st_a, seq[k]);
                    k++;
                end
                prev_tick  = div_y;
                prev_state = st_a;
                step();
                if (st_a != prev_state)
                    check($sformatf("div_cyc%0d_change_on_tick", c), int'(prev_tick), 1);
            end
            check("div_ticks_seen", k, 7);
            use_div = 1'b0;
        end

        // Reset in the middle of a long yellow phase, then a full minimum green before yellow again.
        apply_reset("yel");
        tick_y = 1'b1;
        for (int i = 0; i < 3; i++) step();
        tick_y = 1'b0;
        check("yel_mid_state", st_y, 1);
        check("yel_mid_cnt", int'(u_y.cnt), 1);
        #2;
        reset = 1'b1;
        #1;
        check("yel_rst_state", st_y, 0);
        check("yel_rst_la", la_y, int'(GREEN));
        check("yel_rst_cnt", int'(u_y.cnt), 0);
        step();
        reset = 1'b0;
        tick_y = 1'b1;
        step();
        check("yel_regreen1_state", st_y, 0);
        step();
        check("yel_regreen2_state", st_y, 1);
        tick_y = 1'b0;

        // Tick tied high with minimum dwell: one state per clock, lights never conflict.
        apply_reset("fast");
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("fast%0d_state", i), st_f, i % 4);
            check($sformatf("fast%0d_excl", i), int'(la_f != 2'(RED) && lb_f != 2'(RED)), 0);
            check($sformatf("fast%0d_la_code", i), int'(la_f == 2'b11), 0);
            check($sformatf("fast%0d_lb_code", i), int'(lb_f == 2'b11), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
